// File: rtl/panxi_dpram_be_pkg.sv
// Shared definitions for the byte-strobed dual-port RAM and its clear engine.
// Holds clear-engine state encodings, the byte-lane width and the legal read latencies.
// Pure declarations: no logic, no latency, no flow control.
package panxi_dpram_be_pkg;

    // Width of one write-strobe lane.
    localparam int BYTE_W = 8;

    // Read latencies the output pipeline can be built with.
    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 2;

    // Clear engine states.
    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } clr_state_t;

    function automatic bit rd_latency_ok(input int lat);
        return (lat == RD_LAT_MIN) || (lat == RD_LAT_MAX);
    endfunction

    function automatic bit data_width_ok(input int dw);
        return (dw > 0) && ((dw % BYTE_W) == 0);
    endfunction

endpackage

// File: rtl/panxi_dpram_be_clr_fsm.sv
// Post-reset clear engine: walks every address once, writing zero, then hands the RAM to users.
// Latency: one address per cycle, 2**ADDR_WIDTH cycles of busy after reset release.
// Backpressure: none accepted; busy tells the owner to ignore user requests meanwhile.
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset; restarts the sweep from address 0
//   busy     registered, high while the sweep is running
//   clr_we   write enable for the zero fill
//   clr_addr address being zeroed this cycle
module panxi_dpram_be_clr_fsm
    import panxi_dpram_be_pkg::*;
#(
    parameter int ADDR_WIDTH     = 10,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  busy,
    output logic                  clr_we,
    output logic [ADDR_WIDTH-1:0] clr_addr
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
    localparam logic [ADDR_WIDTH-1:0] ONE       = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    clr_state_t            state;
    logic [ADDR_WIDTH-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            if (CLEAR_ON_RESET != 0) begin
                state <= ST_CLEAR;
                busy  <= 1'b1;
            end else begin
                state <= ST_READY;
                busy  <= 1'b0;
            end
        end else begin
            case (state)
                ST_CLEAR: begin
                    // The top address is the final fill; the counter is held
                    // there instead of wrapping back to zero.
                    if (cnt == LAST_ADDR) begin
                        state <= ST_READY;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
                default: begin
                    state <= ST_READY;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign clr_we   = (state == ST_CLEAR);
    assign clr_addr = cnt;

endmodule

// File: rtl/panxi_dpram_be.sv
// Simple dual-port RAM (one write, one read port) with byte strobes, write-first forwarding
// and an optional post-reset zero fill. Read latency RD_LATENCY (1 or 2) cycles, RVALID pulses with data.
// Backpressure: none; every accepted read produces RVALID, requests are ignored while BUSY.
//
// Ports:
//   ACLK/ARST           clock, synchronous active-high reset
//   WEN/WADDR/WDATA/WSTRB  write request, strobe bit i covers byte i
//   REN/RADDR           read request
//   RDATA/RVALID        read data (held between reads) and its one-cycle valid
//   BUSY                clear engine running; WEN/REN ignored
module panxi_dpram_be
    import panxi_dpram_be_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 10,
    parameter int RD_LATENCY     = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                         ACLK,
    input  logic                         ARST,
    input  logic                         WEN,
    input  logic [ADDR_WIDTH-1:0]        WADDR,
    input  logic [DATA_WIDTH-1:0]        WDATA,
    input  logic [DATA_WIDTH/BYTE_W-1:0] WSTRB,
    input  logic                         REN,
    input  logic [ADDR_WIDTH-1:0]        RADDR,
    output logic [DATA_WIDTH-1:0]        RDATA,
    output logic                         RVALID,
    output logic                         BUSY
);

    localparam int NUM_BYTES = DATA_WIDTH / BYTE_W;
    localparam int DEPTH     = 2 ** ADDR_WIDTH;

    if (!data_width_ok(DATA_WIDTH)) begin : g_bad_data_width
        $error("panxi_dpram_be: DATA_WIDTH must be a positive multiple of 8");
    end
    if (!rd_latency_ok(RD_LATENCY)) begin : g_bad_rd_latency
        $error("panxi_dpram_be: RD_LATENCY must be 1 or 2");
    end

    // Replace the strobed bytes of old_word with the matching bytes of new_word.
    function automatic logic [DATA_WIDTH-1:0] merge_bytes(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [NUM_BYTES-1:0]  strb
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_word;
        for (int b = 0; b < NUM_BYTES; b++) begin
            if (strb[b]) begin
                res[b*BYTE_W +: BYTE_W] = new_word[b*BYTE_W +: BYTE_W];
            end
        end
        return res;
    endfunction

    // ------------------------------------------------------------------
    // Clear engine
    // ------------------------------------------------------------------
    logic                  clr_busy;
    logic                  clr_we;
    logic [ADDR_WIDTH-1:0] clr_addr;

    panxi_dpram_be_clr_fsm #(
        .ADDR_WIDTH     (ADDR_WIDTH),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_clr_fsm (
        .clk      (ACLK),
        .rst      (ARST),
        .busy     (clr_busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // User traffic is dropped while clearing and during the reset cycle itself.
    logic usr_ok;
    logic wr_acc;
    logic rd_acc;
    logic coll;

    assign usr_ok = ~clr_busy & ~ARST;
    assign wr_acc = usr_ok & WEN;
    assign rd_acc = usr_ok & REN;
    assign coll   = wr_acc & (WADDR == RADDR);

    // ------------------------------------------------------------------
    // Write port: clear engine has the port to itself while it runs
    // ------------------------------------------------------------------
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [NUM_BYTES-1:0]  mem_wstrb;

    always_comb begin
        mem_we    = wr_acc;
        mem_addr  = WADDR;
        mem_wdata = WDATA;
        mem_wstrb = WSTRB;
        if (clr_we) begin
            mem_we    = 1'b1;
            mem_addr  = clr_addr;
            mem_wdata = '0;
            mem_wstrb = '1;
        end
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge ACLK) begin
        if (mem_we) begin
            for (int b = 0; b < NUM_BYTES; b++) begin
                if (mem_wstrb[b]) begin
                    mem[mem_addr][b*BYTE_W +: BYTE_W] <= mem_wdata[b*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read stage 1: raw array read plus the colliding write's bytes.
    // The array itself is read-first; write-first behaviour comes from
    // merging the captured write bytes after the register, which keeps
    // the array a plain block RAM and the snapshot fixed at the request edge.
    // ------------------------------------------------------------------
    logic                  s1_vld;
    logic [DATA_WIDTH-1:0] s1_raw;
    logic [DATA_WIDTH-1:0] s1_wdat;
    logic [NUM_BYTES-1:0]  s1_wstrb;
    logic [DATA_WIDTH-1:0] s1_dat;

    always_ff @(posedge ACLK) begin
        if (ARST) begin
            s1_vld   <= 1'b0;
            s1_raw   <= '0;
            s1_wdat  <= '0;
            s1_wstrb <= '0;
        end else begin
            s1_vld <= rd_acc;
            if (rd_acc) begin
                s1_raw   <= mem[RADDR];
                s1_wdat  <= WDATA;
                s1_wstrb <= coll ? WSTRB : '0;
            end
        end
    end

    assign s1_dat = merge_bytes(s1_raw, s1_wdat, s1_wstrb);

    // ------------------------------------------------------------------
    // Optional second output register
    // ------------------------------------------------------------------
    if (RD_LATENCY == 2) begin : g_lat2
        logic                  s2_vld;
        logic [DATA_WIDTH-1:0] s2_dat;

        always_ff @(posedge ACLK) begin
            if (ARST) begin
                s2_vld <= 1'b0;
                s2_dat <= '0;
            end else begin
                s2_vld <= s1_vld;
                if (s1_vld) begin
                    s2_dat <= s1_dat;
                end
            end
        end

        assign RDATA  = s2_dat;
        assign RVALID = s2_vld;
    end else begin : g_lat1
        assign RDATA  = s1_dat;
        assign RVALID = s1_vld;
    end

    assign BUSY = clr_busy;

endmodule

// File: tb/tb_panxi_dpram_be.sv
// Bench for panxi_dpram_be: one instance per read latency, driven by the same stimulus.
// Directed table of per-cycle inputs with hand-computed outputs for both latencies,
// plus sequences for clear timing, reset during clear and reset during a read.
module tb_panxi_dpram_be;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        arst;
    logic        wen;
    logic [3:0]  waddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        ren;
    logic [3:0]  raddr;

    logic [31:0] rdata1, rdata2;
    logic        rvalid1, rvalid2;
    logic        busy1, busy2;

    int n_checks = 0;
    int n_err    = 0;

    panxi_dpram_be #(
        .DATA_WIDTH(32), .ADDR_WIDTH(4), .RD_LATENCY(1), .CLEAR_ON_RESET(1)
    ) u_dut1 (
        .ACLK(clk), .ARST(arst), .WEN(wen), .WADDR(waddr), .WDATA(wdata), .WSTRB(wstrb),
        .REN(ren), .RADDR(raddr), .RDATA(rdata1), .RVALID(rvalid1), .BUSY(busy1)
    );

    panxi_dpram_be #(
        .DATA_WIDTH(32), .ADDR_WIDTH(4), .RD_LATENCY(2), .CLEAR_ON_RESET(1)
    ) u_dut2 (
        .ACLK(clk), .ARST(arst), .WEN(wen), .WADDR(waddr), .WDATA(wdata), .WSTRB(wstrb),
        .REN(ren), .RADDR(raddr), .RDATA(rdata2), .RVALID(rvalid2), .BUSY(busy2)
    );

    typedef struct {
        logic        w;
        logic [3:0]  wa;
        logic [31:0] wd;
        logic [3:0]  ws;
        logic        r;
        logic [3:0]  ra;
        logic        v1;
        logic [31:0] d1;
        logic        v2;
        logic [31:0] d2;
    } vec_t;

    vec_t tbl [22];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        wen   = 1'b0;
        waddr = '0;
        wdata = '0;
        wstrb = '0;
        ren   = 1'b0;
        raddr = '0;
    endtask

    // Called just after the last reset edge with ARST already low. Keeps REN
    // asserted throughout to show reads are ignored while busy.
    task automatic wait_clear(input string tag);
        int n1;
        int n2;
        int n;
        bit bad;
        n1  = 0;
        n2  = 0;
        n   = 0;
        bad = 1'b0;
        ren   = 1'b1;
        raddr = 4'd0;
        while ((busy1 || busy2) && n < 40) begin
            if (rvalid1 || rvalid2) bad = 1'b1;
            if (busy1) n1++;
            if (busy2) n2++;
            step();
            n++;
        end
        if (rvalid1 || rvalid2) bad = 1'b1;
        ren = 1'b0;
        chk({tag, " lat1 busy cycles"}, n1, 16);
        chk({tag, " lat2 busy cycles"}, n2, 16);
        chk({tag, " no rvalid while busy"}, {31'd0, bad}, 0);
    endtask

    initial begin
        // Hand-computed per-cycle vectors; d1/v1 are the latency-1 outputs
        // after this row's edge, d2/v2 the latency-2 outputs.
        tbl[0]  = '{1'b1, 4'd3,  32'hDEADBEEF, 4'hF, 1'b0, 4'd0,  1'b0, 32'h00000000, 1'b0, 32'h00000000};
        tbl[1]  = '{1'b1, 4'd3,  32'h0000AA00, 4'h2, 1'b0, 4'd0,  1'b0, 32'h00000000, 1'b0, 32'h00000000};
        tbl[2]  = '{1'b0, 4'd0,  32'h00000000, 4'h0, 1'b1, 4'd3,  1'b1, 32'hDEADAAEF, 1'b0, 32'h00000000};
        tbl[3]  = '{1'b1, 4'd5,  32'h11223344, 4'hF, 1'b0, 4'd0,  1'b0, 32'hDEADAAEF, 1'b1, 32'hDEADAAEF};
        tbl[4]  = '{1'b1, 4'd5,  32'hAABBCCDD, 4'h9, 1'b1, 4'd5,  1'b1, 32'hAA2233DD, 1'b0, 32'hDEADAAEF};
        tbl[5]  = '{1'b1, 4'd0,  32'h00000001, 4'hF, 1'b0, 4'd0,  1'b0, 32'hAA2233DD, 1'b1, 32'hAA2233DD};
        tbl[6]  = '{1'b1, 4'd1,  32'h00000002, 4'hF, 1'b0, 4'd0,  1'b0, 32'hAA2233DD, 1'b0, 32'hAA2233DD};
        tbl[7]  = '{1'b1, 4'd2,  32'h00000003, 4'hF, 1'b1, 4'd0,  1'b1, 32'h00000001, 1'b0, 32'hAA2233DD};
        tbl[8]  = '{1'b0, 4'd0,  32'h00000000, 4'h0, 1'b1, 4'd1,  1'b1, 32'h00000002, 1'b1, 32'h00000001};
        tbl[9]  = '{1'b0, 4'd0,  32'h00000000, 4'h0, 1'b1, 4'd2,  1'b1, 32'h00000003, 1'b1, 32'h00000002};
        tbl[10] = '{1'b1, 4'd2,  32'h55667788, 4'hF, 1'b0, 4'd0,  1'b0, 32'h00000003, 1'b1, 32'h00000003};
        tbl[11] = '{1'b0, 4'd0,  32'h00000000, 4'h0, 1'b1, 4'd2,  1'b1, 32'h55667788, 1'b0, 32'h00000003};
        tbl[12] = '{1'b1, 4'd2,  32'hCAFEF00D, 4'hF, 1'b0, 4'd0,  1'b0, 32'h55667788, 1'b1, 32'h55667788};
        tbl[13] = '{1'b0, 4'd0,  32'h00000000, 4'h0, 1'b1, 4'd2,  1'b1, 32'hCAFEF00D, 1'b0, 32'h55667788};
        tbl[14] = '{1'b1, 4'd2,  32'hFFFFFFFF, 4'h0, 1'b0, 4'd0,  1'b0, 32'hCAFEF00D, 1'b1, 32'hCAFEF00D};
        tbl[15] = '{1'b0, 4'd0,  32'h00000000, 4'h0, 1'b1, 4'd2,  1'b1, 32'hCAFEF00D, 1'b0, 32'hCAFEF00D};
        tbl[16] = '{1'b0, 4'd0,  32'h00000000, 4'h0, 1'b0, 4'd0,  1'b0, 32'hCAFEF00D, 1'b1, 32'hCAFEF00D};
        tbl[17] = '{1'b1, 4'd15, 32'h89ABCDEF, 4'hF, 1'b1, 4'd15, 1'b1, 32'h89ABCDEF, 1'b0, 32'hCAFEF00D};
        tbl[18] = '{1'b0, 4'd0,  32'h00000000, 4'h0, 1'b0, 4'd0,  1'b0, 32'h89ABCDEF, 1'b1, 32'h89ABCDEF};
        tbl[19] = '{1'b1, 4'd5,  32'h00FF00FF, 4'h6, 1'b1, 4'd5,  1'b1, 32'hAAFF00DD, 1'b0, 32'h89ABCDEF};
        tbl[20] = '{1'b0, 4'd0,  32'h00000000, 4'h0, 1'b1, 4'd5,  1'b1, 32'hAAFF00DD, 1'b1, 32'hAAFF00DD};
        tbl[21] = '{1'b0, 4'd0,  32'h00000000, 4'h0, 1'b0, 4'd0,  1'b0, 32'hAAFF00DD, 1'b1, 32'hAAFF00DD};

        // ---------------- power-on reset and first clear ----------------
        arst = 1'b1;
        idle_inputs();
        step();
        step();
        chk("reset rdata1", rdata1, 32'h0);
        chk("reset rvalid1", {31'd0, rvalid1}, 0);
        chk("reset busy1", {31'd0, busy1}, 1);
        chk("reset rdata2", rdata2, 32'h0);
        chk("reset rvalid2", {31'd0, rvalid2}, 0);
        chk("reset busy2", {31'd0, busy2}, 1);
        arst = 1'b0;
        wait_clear("clr0");
        idle_inputs();
        step();

        // ---------------- table-driven read/write vectors ----------------
        for (int i = 0; i < 22; i++) begin
            wen   = tbl[i].w;
            waddr = tbl[i].wa;
            wdata = tbl[i].wd;
            wstrb = tbl[i].ws;
            ren   = tbl[i].r;
            raddr = tbl[i].ra;
            step();
            chk($sformatf("row%0d rvalid1", i), {31'd0, rvalid1}, {31'd0, tbl[i].v1});
            chk($sformatf("row%0d rdata1", i), rdata1, tbl[i].d1);
            chk($sformatf("row%0d rvalid2", i), {31'd0, rvalid2}, {31'd0, tbl[i].v2});
            chk($sformatf("row%0d rdata2", i), rdata2, tbl[i].d2);
        end
        idle_inputs();

        // ---------------- reset while a latency-2 read is in flight ----------------
        ren   = 1'b1;
        raddr = 4'd5;
        step();
        chk("inflight rvalid1", {31'd0, rvalid1}, 1);
        chk("inflight rdata1", rdata1, 32'hAAFF00DD);
        ren  = 1'b0;
        arst = 1'b1;
        step();
        chk("rst mid-read rvalid1", {31'd0, rvalid1}, 0);
        chk("rst mid-read rvalid2", {31'd0, rvalid2}, 0);
        chk("rst mid-read rdata1", rdata1, 32'h0);
        chk("rst mid-read rdata2", rdata2, 32'h0);
        chk("rst mid-read busy1", {31'd0, busy1}, 1);
        chk("rst mid-read busy2", {31'd0, busy2}, 1);

        // ---------------- reset again once the counter reaches 7 ----------------
        begin
            bit bad7;
            bad7  = 1'b0;
            arst  = 1'b0;
            ren   = 1'b1;
            raddr = 4'd3;
            for (int i = 0; i < 7; i++) begin
                step();
                if (rvalid1 || rvalid2 || !busy1 || !busy2) bad7 = 1'b1;
            end
            chk("partial clear busy, no rvalid", {31'd0, bad7}, 0);
        end
        arst = 1'b1;
        step();
        arst = 1'b0;
        wait_clear("clr1");

        // ---------------- every word reads back zero after the fill ----------------
        for (int a = 0; a < 18; a++) begin
            ren   = (a < 16);
            raddr = a[3:0];
            step();
            chk($sformatf("zero a%0d rvalid1", a), {31'd0, rvalid1}, {31'd0, (a < 16)});
            chk($sformatf("zero a%0d rdata1", a), rdata1, 32'h0);
            chk($sformatf("zero a%0d rvalid2", a), {31'd0, rvalid2}, {31'd0, (a >= 1 && a <= 16)});
            chk($sformatf("zero a%0d rdata2", a), rdata2, 32'h0);
        end
        idle_inputs();
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
